if_scratch_ring_buffer: RTL and testbench
=========================================

Name: if_scratch_ring_buffer

Overview:
- Parametrised successor to the IF scratchpad. Input-feature storage organised as a circular buffer with occupancy tracking.
- Adds full/empty flags, window-relative reads (base + offset) with a valid-qualified registered output, out-of-window read error, and bulk release of consumed entries for stride advance.
- Sits between the IF input stream and the PE datapath. The PE controller reads a sliding window and releases the oldest entries as the window moves.

Parameters:
- SCRATCH_WIDTH, 8, data word width in bits.
- SCRATCH_ADDRESS_SIZE, 4, address bits; DEPTH = 2**SCRATCH_ADDRESS_SIZE entries.
- CNT_W, SCRATCH_ADDRESS_SIZE+1, width of occupancy and release counts; must hold 0..DEPTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- write_en  input  1  push din at the write pointer
- din  input  SCRATCH_WIDTH  write data
- read_en  input  1  read request
- read_offset  input  SCRATCH_ADDRESS_SIZE  offset from base_addr
- release_en  input  1  discard the oldest entries
- release_cnt  input  CNT_W  number of entries to discard
- dout  output  SCRATCH_WIDTH  registered read data
- dout_valid  output  1  dout updated this cycle
- rd_err  output  1  registered pulse: out-of-window read
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  CNT_W  current occupancy
- base_addr  output  SCRATCH_ADDRESS_SIZE  physical address of the oldest entry
- last_write  output  SCRATCH_ADDRESS_SIZE  next physical write address (write pointer)

Behaviour:
- Reset (async): write pointer = 0, base_addr = 0, count = 0, dout = 0, dout_valid = 0, rd_err = 0. Memory contents are not reset. full = 0, empty = 1.
- Write:
  - Accepted iff write_en && !full, using full as registered at the start of the cycle.
  - Accepted write stores din at mem[wp], then wp <= wp+1 mod DEPTH (natural wrap).
  - write_en while full is dropped: no state change.
- Read (latency 1):
  - If read_en && read_offset < count (pre-update count), then next cycle dout = mem[(base_addr+read_offset) mod DEPTH] and dout_valid = 1.
  - If read_en && read_offset >= count, then next cycle dout_valid = 0, rd_err = 1, and dout holds its previous value.
  - If !read_en, dout_valid = 0, rd_err = 0, and dout holds.
  - The read uses base_addr and memory before any same-cycle write or release, so a read never returns data written in the same cycle.
- Release:
  - rel = min(release_cnt, count) (pre-update). base_addr <= base_addr + rel mod DEPTH.
  - A released slot's data is not cleared.
- Occupancy: count <= count + wr_acc - rel each cycle, computed in CNT_W+1 bits. The result never exceeds DEPTH and never goes below 0.
- Simultaneous events:
  - write + release in the same cycle with full = 1: the write is still dropped (full is evaluated pre-release).
  - write + release with count < DEPTH: both take effect.
  - read + release: the read resolves against the old base.
- Flags full/empty are decoded combinationally from the registered count.
- Reset asserted mid-operation clears all state immediately. Any pending read result is lost (dout_valid = 0).

Optional Feature:
- Macro: IF_SCRATCH_DROP_CNT_EN.
- Defined:
  - Adds output port drop_count (16 bits), reset to 0.
  - Increments on every cycle with write_en && full, saturating at 16'hFFFF.
  - Adds output overflow_sticky (1 bit), set on the first dropped write and cleared only by rst.
- Undefined: neither port nor its logic exists, and dropped writes are silent. All other behaviour is identical.

Test Plan (SCRATCH_ADDRESS_SIZE = 2, DEPTH = 4, SCRATCH_WIDTH = 8):
- Reset then fill: write 8'h11, 8'h22, 8'h33, 8'h44 -> count = 4, full = 1, last_write = 0; a fifth write of 8'h55 is dropped, count stays 4, and drop_count = 1 when the macro is defined.
- Windowed read: after the fill, read_offset = 2 -> next cycle dout = 8'h33, dout_valid = 1; read_offset = 3 -> 8'h44.
- Release and wrap: release_cnt = 2 -> base_addr = 2, count = 2; write 8'h55 and 8'h66 (to physical addresses 0 and 1); read_offset = 3 -> dout = 8'h66.
- Out-of-window read: count = 2, read_offset = 2 -> next cycle rd_err = 1, dout_valid = 0, dout unchanged.
- Over-release with simultaneous write: count = 1, release_cnt = 3 while writing 8'h77 -> count = 1, base_addr advances by 1, empty = 0.
- Async reset mid-read: read_en issued and rst pulsed before the next clock edge -> dout = 0, dout_valid = 0, count = 0, empty = 1 immediately.

Source files
------------

// File: rtl/if_scratch_ring_buffer_if.sv
// Bus interface for if_scratch_ring_buffer: write stream, windowed read
// request/response, bulk release and occupancy status.
// master = PE controller / stream side, slave = the ring buffer.
interface if_scratch_ring_buffer_if #(
    parameter int SCRATCH_WIDTH        = 8,
    parameter int SCRATCH_ADDRESS_SIZE = 4,
    parameter int CNT_W                = SCRATCH_ADDRESS_SIZE + 1
);
    logic                            write_en;
    logic [SCRATCH_WIDTH-1:0]        din;
    logic                            read_en;
    logic [SCRATCH_ADDRESS_SIZE-1:0] read_offset;
    logic                            release_en;
    logic [CNT_W-1:0]                release_cnt;
    logic [SCRATCH_WIDTH-1:0]        dout;
    logic                            dout_valid;
    logic                            rd_err;
    logic                            full;
    logic                            empty;
    logic [CNT_W-1:0]                count;
    logic [SCRATCH_ADDRESS_SIZE-1:0] base_addr;
    logic [SCRATCH_ADDRESS_SIZE-1:0] last_write;

    modport master (
        output write_en, din, read_en, read_offset, release_en, release_cnt,
        input  dout, dout_valid, rd_err, full, empty, count, base_addr, last_write
    );

    modport slave (
        input  write_en, din, read_en, read_offset, release_en, release_cnt,
        output dout, dout_valid, rd_err, full, empty, count, base_addr, last_write
    );
endinterface

// File: rtl/if_scratch_ring_buffer.sv
// Input-feature scratchpad organised as a circular buffer with occupancy
// tracking, window-relative registered reads (base_addr + offset), an
// out-of-window read error pulse and bulk release of the oldest entries.
// Optional feature macro IF_SCRATCH_DROP_CNT_EN adds a saturating 16-bit
// dropped-write counter (drop_count) and a sticky overflow flag.
module if_scratch_ring_buffer #(
    parameter int SCRATCH_WIDTH        = 8,
    parameter int SCRATCH_ADDRESS_SIZE = 4,
    parameter int CNT_W                = SCRATCH_ADDRESS_SIZE + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    if_scratch_ring_buffer_if.slave     bus
`ifdef IF_SCRATCH_DROP_CNT_EN
    ,
    output logic [15:0]                 drop_count,
    output logic                        overflow_sticky
`endif
);
    localparam int                DEPTH     = 1 << SCRATCH_ADDRESS_SIZE;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

    logic [SCRATCH_WIDTH-1:0]        mem_r [DEPTH];
    logic [SCRATCH_ADDRESS_SIZE-1:0] wp_r;
    logic [SCRATCH_ADDRESS_SIZE-1:0] base_r;
    logic [CNT_W-1:0]                count_r;
    logic [SCRATCH_WIDTH-1:0]        dout_r;
    logic                            dout_valid_r;
    logic                            rd_err_r;

    logic                            full_s;
    logic                            empty_s;
    logic                            wr_acc_s;
    logic                            rd_hit_s;
    logic [SCRATCH_ADDRESS_SIZE-1:0] rd_addr_s;
    logic [CNT_W-1:0]                rel_s;
    logic [CNT_W:0]                  sum_s;
    logic [CNT_W-1:0]                count_next_s;

    // Status flags decoded from the registered occupancy.
    assign full_s  = (count_r == DEPTH_CNT);
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // Decode write acceptance, read window hit, clamped release and next occupancy.
    always_comb begin
        wr_acc_s  = bus.write_en && !full_s;
        rd_hit_s  = bus.read_en && (CNT_W'(bus.read_offset) < count_r);
        rd_addr_s = base_r + bus.read_offset;
        rel_s     = {CNT_W{1'b0}};
        if (bus.release_en) begin
            if (bus.release_cnt < count_r) begin
                rel_s = bus.release_cnt;
            end else begin
                rel_s = count_r;
            end
        end else begin
            rel_s = {CNT_W{1'b0}};
        end
        sum_s = {1'b0, count_r} + {{CNT_W{1'b0}}, wr_acc_s} - {1'b0, rel_s};
        // The release is clamped to count, so the extra bit never sets; clamp anyway.
        if (sum_s[CNT_W]) begin
            count_next_s = {CNT_W{1'b0}};
        end else begin
            count_next_s = sum_s[CNT_W-1:0];
        end
    end

    // Storage array: written on accepted pushes, never reset or cleared on release.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wp_r] <= bus.din;
        end
    end

    // Pointers, occupancy and the registered read response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_r         <= {SCRATCH_ADDRESS_SIZE{1'b0}};
            base_r       <= {SCRATCH_ADDRESS_SIZE{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            dout_r       <= {SCRATCH_WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
            rd_err_r     <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wp_r <= wp_r + {{(SCRATCH_ADDRESS_SIZE-1){1'b0}}, 1'b1};
            end
            base_r  <= base_r + rel_s[SCRATCH_ADDRESS_SIZE-1:0];
            count_r <= count_next_s;
            // Read sees pre-write memory and pre-release base.
            if (rd_hit_s) begin
                dout_r <= mem_r[rd_addr_s];
            end
            dout_valid_r <= rd_hit_s;
            rd_err_r     <= bus.read_en && !rd_hit_s;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.rd_err     = rd_err_r;
    assign bus.full       = full_s;
    assign bus.empty      = empty_s;
    assign bus.count      = count_r;
    assign bus.base_addr  = base_r;
    assign bus.last_write = wp_r;

`ifdef IF_SCRATCH_DROP_CNT_EN
    logic [15:0] drop_r;
    logic        sticky_r;

    // Count writes attempted while full (saturating) and latch the first one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_r   <= 16'h0000;
            sticky_r <= 1'b0;
        end else begin
            if (bus.write_en && full_s) begin
                sticky_r <= 1'b1;
                if (drop_r != 16'hFFFF) begin
                    drop_r <= drop_r + 16'h0001;
                end
            end
        end
    end

    assign drop_count      = drop_r;
    assign overflow_sticky = sticky_r;
`endif

endmodule

// File: tb/tb_if_scratch_ring_buffer.sv
// Self-checking bench for if_scratch_ring_buffer (DEPTH = 4, 8-bit words):
// a table of per-cycle vectors with hand-computed results, then an
// asynchronous reset applied in the middle of a pending read.
module tb_if_scratch_ring_buffer;
    logic clk;
    logic rst;

    if_scratch_ring_buffer_if #(
        .SCRATCH_WIDTH(8), .SCRATCH_ADDRESS_SIZE(2), .CNT_W(3)
    ) bus ();

`ifdef IF_SCRATCH_DROP_CNT_EN
    logic [15:0] drop_count;
    logic        overflow_sticky;
`endif

    if_scratch_ring_buffer #(
        .SCRATCH_WIDTH(8), .SCRATCH_ADDRESS_SIZE(2), .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef IF_SCRATCH_DROP_CNT_EN
        ,
        .drop_count(drop_count),
        .overflow_sticky(overflow_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] din;
        logic       re;
        logic [1:0] off;
        logic       rl;
        logic [2:0] rc;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic [1:0] base;
        logic [1:0] lw;
        logic       dv;
        logic [7:0] dout;
        logic       err;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    int n_cmp;
    int n_bad;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_state(input int idx, input vec_t v);
        chk("count",      idx, 32'(bus.count),      32'(v.cnt));
        chk("full",       idx, 32'(bus.full),       32'(v.full));
        chk("empty",      idx, 32'(bus.empty),      32'(v.empty));
        chk("base_addr",  idx, 32'(bus.base_addr),  32'(v.base));
        chk("last_write", idx, 32'(bus.last_write), 32'(v.lw));
        chk("dout_valid", idx, 32'(bus.dout_valid), 32'(v.dv));
        chk("dout",       idx, 32'(bus.dout),       32'(v.dout));
        chk("rd_err",     idx, 32'(bus.rd_err),     32'(v.err));
    endtask

    task automatic drive_idle();
        bus.write_en    = 1'b0;
        bus.din         = 8'h00;
        bus.read_en     = 1'b0;
        bus.read_offset = 2'd0;
        bus.release_en  = 1'b0;
        bus.release_cnt = 3'd0;
    endtask

    initial begin
        vec_t rv;
        n_cmp = 0;
        n_bad = 0;

        //          we    din    re    off   rl    rc    cnt   full  empty base  lw    dv    dout   err
        // Fill to full, then a dropped fifth write.
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 2'd0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 2'd0, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 2'd0, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 2'd0, 1'b0, 3'd0, 3'd4, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 8'h55, 1'b0, 2'd0, 1'b0, 3'd0, 3'd4, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0};
        // Windowed reads.
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 2'd2, 1'b0, 3'd0, 3'd4, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 8'h33, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 2'd3, 1'b0, 3'd0, 3'd4, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 8'h44, 1'b0};
        // Release two, refill with wrap, read across the wrap.
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 3'd2, 3'd2, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 8'h44, 1'b0};
        vecs[8]  = '{1'b1, 8'h55, 1'b0, 2'd0, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 8'h44, 1'b0};
        vecs[9]  = '{1'b1, 8'h66, 1'b0, 2'd0, 1'b0, 3'd0, 3'd4, 1'b1, 1'b0, 2'd2, 2'd2, 1'b0, 8'h44, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 2'd3, 1'b0, 3'd0, 3'd4, 1'b1, 1'b0, 2'd2, 2'd2, 1'b1, 8'h66, 1'b0};
        // Out-of-window read with count = 2: dout holds 66.
        vecs[11] = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 3'd2, 3'd2, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 8'h66, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 2'd2, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 8'h66, 1'b1};
        // Read + release: read resolves against the old base (mem[0] = 55).
        vecs[13] = '{1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 2'd1, 2'd2, 1'b1, 8'h55, 1'b0};
        // Over-release with simultaneous write of 77 (to mem[2]).
        vecs[14] = '{1'b1, 8'h77, 1'b0, 2'd0, 1'b1, 3'd3, 3'd1, 1'b0, 1'b0, 2'd2, 2'd3, 1'b0, 8'h55, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 2'd2, 2'd3, 1'b1, 8'h77, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 2'd1, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 2'd2, 2'd3, 1'b0, 8'h77, 1'b1};
        // Refill to full, then write + release while full: write dropped.
        vecs[17] = '{1'b1, 8'h88, 1'b0, 2'd0, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 8'h77, 1'b0};
        vecs[18] = '{1'b1, 8'h99, 1'b0, 2'd0, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 8'h77, 1'b0};
        vecs[19] = '{1'b1, 8'hAA, 1'b0, 2'd0, 1'b0, 3'd0, 3'd4, 1'b1, 1'b0, 2'd2, 2'd2, 1'b0, 8'h77, 1'b0};
        vecs[20] = '{1'b1, 8'hBB, 1'b0, 2'd0, 1'b1, 3'd1, 3'd3, 1'b0, 1'b0, 2'd3, 2'd2, 1'b0, 8'h77, 1'b0};
        vecs[21] = '{1'b0, 8'h00, 1'b1, 2'd2, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0, 2'd3, 2'd2, 1'b1, 8'hAA, 1'b0};
        // Release more than held: drains to empty.
        vecs[22] = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 3'd7, 3'd0, 1'b0, 1'b1, 2'd2, 2'd2, 1'b0, 8'hAA, 1'b0};

        // Reset state.
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        rv = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0};
        chk_state(-1, rv);
`ifdef IF_SCRATCH_DROP_CNT_EN
        chk("drop_count_rst", -1, 32'(drop_count), 32'd0);
        chk("sticky_rst",     -1, 32'(overflow_sticky), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            bus.write_en    = vecs[i].we;
            bus.din         = vecs[i].din;
            bus.read_en     = vecs[i].re;
            bus.read_offset = vecs[i].off;
            bus.release_en  = vecs[i].rl;
            bus.release_cnt = vecs[i].rc;
            @(posedge clk);
            #1;
            chk_state(i, vecs[i]);
`ifdef IF_SCRATCH_DROP_CNT_EN
            if (i == 4) begin
                chk("drop_count_first", i, 32'(drop_count), 32'd1);
                chk("sticky_first",     i, 32'(overflow_sticky), 32'd1);
            end
`endif
            @(negedge clk);
        end

`ifdef IF_SCRATCH_DROP_CNT_EN
        chk("drop_count_end", NV, 32'(drop_count), 32'd2);
        chk("sticky_end",     NV, 32'(overflow_sticky), 32'd1);
`endif

        // Async reset while a read is pending: write CC, read it, reset before the edge.
        drive_idle();
        bus.write_en = 1'b1;
        bus.din      = 8'hCC;
        @(posedge clk);
        #1;
        chk("pre_reset_count", 100, 32'(bus.count), 32'd1);
        @(negedge clk);
        drive_idle();
        bus.read_en     = 1'b1;
        bus.read_offset = 2'd0;
        #2;
        rst = 1'b1;
        #1;
        rv = '{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0};
        chk_state(101, rv);
`ifdef IF_SCRATCH_DROP_CNT_EN
        chk("drop_count_mid_rst", 101, 32'(drop_count), 32'd0);
        chk("sticky_mid_rst",     101, 32'(overflow_sticky), 32'd0);
`endif
        // Hold reset across an edge: pending read must not surface.
        @(posedge clk);
        #1;
        chk("dout_valid_in_rst", 102, 32'(bus.dout_valid), 32'd0);
        chk("dout_in_rst",       102, 32'(bus.dout), 32'd0);
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("empty_after_rst", 103, 32'(bus.empty), 32'd1);
        chk("rd_err_after_rst", 103, 32'(bus.rd_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
